// File: rtl/uart_cmd_slave.sv
// ----------------------------------------------------------------------------
// uart_cmd_slave
//   Far-end UART command target. Receives two-byte {hdr, wdata} write
//   commands or one-byte hdr read commands from the host. Writes go out on a
//   register-file strobe port. Reads fetch one byte and return it to the host
//   as a single UART frame after a fixed turnaround gap.
//   Frame format: start(0), 8 data bits LSB first, odd parity (~^data), stop(1).
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         serial input from the host (asynchronous, idle high)
//   tx         serial output to the host (idle high)
//   reg_addr   register address, taken from hdr[6:0]
//   reg_wdata  register write data
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe
//   reg_rdata  read data, valid exactly one cycle after reg_re
//   busy       high while a command is in progress (any state but C_HDR)
//   frame_err  one-cycle pulse on parity error, stop error or wdata timeout
// ----------------------------------------------------------------------------
module uart_cmd_slave #(
    parameter int BR       = 434,   // clocks per bit
    parameter int TURN_DLY = 434,   // clocks from read-data capture to tx start bit
    parameter int FRAME_TO = 8192   // clocks allowed to wait for the wdata frame
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err
);

    localparam int TMAX = (BR > TURN_DLY) ? BR : TURN_DLY;
    localparam int RXW  = (BR > 2) ? $clog2(BR) : 1;
    localparam int TXW  = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int TOW  = $clog2(FRAME_TO + 1);

    localparam logic [RXW-1:0] RX_HALF   = RXW'(BR / 2);
    localparam logic [RXW-1:0] RX_LAST   = RXW'(BR - 1);
    localparam logic [TXW-1:0] BIT_LAST  = TXW'(BR - 1);
    localparam logic [TXW-1:0] TURN_LAST = TXW'(TURN_DLY - 1);
    localparam logic [TOW-1:0] TO_LIMIT  = TOW'(FRAME_TO);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        C_HDR, C_WDATA, C_WRITE, C_READ, C_CAP, C_TURN, C_TX
    } cmd_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t        r_rx_state;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [RXW-1:0]   r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_par_err;
    logic             r_byte_vld;
    logic             r_rx_err;

    logic             w_rx_fall;
    logic             w_rx_mid;

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;
    assign w_rx_mid  = (r_rx_cnt == RX_HALF);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; every register is cleared in this branch,
        // and the synchroniser flops are preset to the idle-high line level so
        // leaving reset never looks like a start edge.
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= R_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_err <= 1'b0;
            r_byte_vld   <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic, so
            // every right-hand side sees the pre-edge value regardless of order.
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_byte_vld <= 1'b0;
            r_rx_err   <= 1'b0;

            if (r_rx_state != R_IDLE) begin
                r_rx_cnt <= (r_rx_cnt == RX_LAST) ? '0 : r_rx_cnt + 1'b1;
            end

            // The bit counter free-runs across bits, so each state moves on
            // at its own mid-bit sample and the next sample lands one BR later.
            case (r_rx_state)
                R_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= R_START;
                        r_rx_cnt   <= '0;
                    end
                end
                R_START: begin
                    if (w_rx_mid) begin
                        if (r_rx_sync) begin
                            r_rx_state <= R_IDLE;   // glitch, not a start bit
                        end else begin
                            r_rx_state <= R_DATA;
                            r_rx_bit   <= '0;
                        end
                    end
                end
                R_DATA: begin
                    if (w_rx_mid) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= R_PAR;
                        end
                    end
                end
                R_PAR: begin
                    if (w_rx_mid) begin
                        r_rx_par_err <= (r_rx_sync != ~^r_rx_shift);
                        r_rx_state   <= R_STOP;
                    end
                end
                R_STOP: begin
                    if (w_rx_mid) begin
                        if (!r_rx_sync || r_rx_par_err) begin
                            r_rx_err <= 1'b1;
                        end else begin
                            r_byte_vld <= 1'b1;
                        end
                        r_rx_state <= R_IDLE;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command FSM and transmitter
    // ------------------------------------------------------------------
    cmd_state_t       r_cstate;
    logic [6:0]       r_hdr_addr;
    logic [TOW-1:0]   r_to_cnt;
    logic [TXW-1:0]   r_tx_cnt;
    logic [3:0]       r_tx_bit;
    logic [9:0]       r_tx_shift;   // bits still to send after the start bit
    logic             r_tx;
    logic [6:0]       r_reg_addr;
    logic [7:0]       r_reg_wdata;
    logic             r_reg_we;
    logic             r_reg_re;
    logic             r_busy;
    logic             r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate    <= C_HDR;
            r_hdr_addr  <= '0;
            r_to_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '1;
            r_tx        <= 1'b1;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_cstate)
                C_HDR: begin
                    if (r_byte_vld) begin
                        r_hdr_addr <= r_rx_shift[6:0];
                        r_busy     <= 1'b1;
                        if (r_rx_shift[7]) begin
                            r_cstate <= C_WDATA;
                            r_to_cnt <= '0;
                        end else begin
                            r_cstate   <= C_READ;
                            r_reg_addr <= r_rx_shift[6:0];
                            r_reg_re   <= 1'b1;
                        end
                    end else if (r_rx_err) begin
                        r_frame_err <= 1'b1;
                    end
                end
                C_WDATA: begin
                    // A completed frame wins over the timeout in the same cycle.
                    if (r_byte_vld) begin
                        r_cstate    <= C_WRITE;
                        r_reg_addr  <= r_hdr_addr;
                        r_reg_wdata <= r_rx_shift;
                        r_reg_we    <= 1'b1;
                    end else if (r_rx_err) begin
                        r_cstate    <= C_HDR;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                    end else if (r_to_cnt == TO_LIMIT) begin
                        // Only give up once no frame is in flight.
                        if (r_rx_state == R_IDLE) begin
                            r_cstate    <= C_HDR;
                            r_busy      <= 1'b0;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                C_WRITE: begin
                    r_cstate <= C_HDR;
                    r_busy   <= 1'b0;
                end
                C_READ: begin
                    r_cstate <= C_CAP;
                end
                C_CAP: begin
                    r_tx_shift <= {1'b1, ~^reg_rdata, reg_rdata};
                    r_tx_cnt   <= '0;
                    r_cstate   <= C_TURN;
                end
                C_TURN: begin
                    if (r_tx_cnt == TURN_LAST) begin
                        r_tx     <= 1'b0;   // start bit
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        r_cstate <= C_TX;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                C_TX: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 4'd10) begin
                            // Stop bit finished; the line is already high.
                            r_cstate <= C_HDR;
                            r_busy   <= 1'b0;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cstate <= C_HDR;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign tx        = r_tx;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_re    = r_reg_re;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_slave
//   Directed plus randomized bench for uart_cmd_slave with short bit times.
//   The expected results come from the frame rules: a byte with bit 7 set is
//   a write header followed by a data byte, otherwise it is a read whose reply
//   is {stop, ~^d, d, start}; the register file is a plain array in the bench.
// ----------------------------------------------------------------------------
module tb_uart_cmd_slave;

    localparam int BR       = 16;
    localparam int TURN_DLY = 24;
    localparam int FRAME_TO = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tx;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_cmd_slave #(.BR(BR), .TURN_DLY(TURN_DLY), .FRAME_TO(FRAME_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx        (tx),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int tests = 0;
    int fails = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file seen by the read port; data is valid only the cycle after
    // reg_re, otherwise the inverted value is presented.
    logic [7:0] rf [128];
    always @(posedge clk) reg_rdata <= reg_re ? rf[reg_addr] : ~rf[reg_addr];

    // Event monitors, sampled on the falling edge.
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          fe_cnt = 0;
    int          busy_cyc = 0;
    int          txlow_cyc = 0;
    logic [14:0] we_log [64];
    logic [6:0]  re_log [64];
    int unsigned last_re_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                if (we_cnt < 64) we_log[we_cnt] = {reg_addr, reg_wdata};
                we_cnt++;
            end
            if (reg_re) begin
                if (re_cnt < 64) re_log[re_cnt] = reg_addr;
                re_cnt++;
                last_re_cyc = cyc;
            end
            if (frame_err) fe_cnt++;
            if (busy) busy_cyc++;
            if (tx !== 1'b1) txlow_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        rx = 1'b0;
        tick(BR);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BR);
        end
        rx = (~^d) ^ bad_par;
        tick(BR);
        rx = ~bad_stop;
        tick(BR);
        rx = 1'b1;
    endtask

    // Capture one reply frame and compare it with the frame built from d.
    task automatic expect_tx(input string tag, input logic [7:0] d);
        int          w;
        logic [10:0] exp_bits;
        logic [10:0] obs_bits;
        int unsigned t0;
        exp_bits = {1'b1, ~^d, d, 1'b0};
        obs_bits = '0;
        w = 0;
        while (tx !== 1'b0 && w < TURN_DLY + 4 * BR) begin
            @(negedge clk);
            w++;
        end
        t0 = cyc;
        check({tag, "_txstart"}, {31'd0, tx}, 32'd0);
        // reg_re cycle, data valid one cycle later, captured at the end of
        // that cycle, then TURN_DLY clocks to the start bit.
        check({tag, "_turnaround"}, t0 - last_re_cyc, TURN_DLY + 2);
        tick(BR / 2 - 1);
        for (int i = 0; i < 11; i++) begin
            obs_bits[i] = tx;
            if (i < 10) tick(BR);
        end
        check({tag, "_busy_in_stop"}, {31'd0, busy}, 32'd1);
        check({tag, "_frame"}, {21'd0, obs_bits}, {21'd0, exp_bits});
        tick(BR - BR / 2 + 1);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
    endtask

    // Full read transaction: header, strobe, reply.
    task automatic do_read(input string tag, input logic [6:0] a);
        int re0;
        re0 = re_cnt;
        send_frame({1'b0, a}, 1'b0, 1'b0);
        check({tag, "_re_count"}, re_cnt - re0, 1);
        check({tag, "_re_addr"}, {25'd0, re_log[re0 % 64]}, {25'd0, a});
        expect_tx(tag, rf[a]);
    endtask

    // Full write transaction with a gap between the two frames.
    task automatic do_write(input string tag, input logic [6:0] a, input logic [7:0] d, input int gap);
        int we0;
        we0 = we_cnt;
        send_frame({1'b1, a}, 1'b0, 1'b0);
        check({tag, "_busy_hdr"}, {31'd0, busy}, 32'd1);
        tick(gap);
        send_frame(d, 1'b0, 1'b0);
        tick(2);
        check({tag, "_we_count"}, we_cnt - we0, 1);
        check({tag, "_we_data"}, {17'd0, we_log[we0 % 64]}, {17'd0, a, d});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fe0, we0, re0, busy0, txl0, w;
        logic [7:0]  last_wdata;
        logic [6:0]  a;
        logic [7:0]  d;

        for (int i = 0; i < 128; i++) rf[i] = 8'($urandom);
        rf[7'h05] = 8'hA7;
        last_wdata = 8'h00;

        // ---- reset state
        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        check("rst_tx",        {31'd0, tx},        32'd1);
        check("rst_we",        {31'd0, reg_we},    32'd0);
        check("rst_re",        {31'd0, reg_re},    32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_addr",      {25'd0, reg_addr},  32'd0);
        check("rst_wdata",     {24'd0, reg_wdata}, 32'd0);
        rst = 1'b0;
        tick(5);

        // ---- 1: write 0x85, 0x3C
        txl0 = txlow_cyc;
        fe0  = fe_cnt;
        do_write("t1_write", 7'h05, 8'h3C, 0);
        last_wdata = 8'h3C;
        check("t1_addr_hold", {25'd0, reg_addr}, 32'h05);
        check("t1_tx_quiet", txlow_cyc - txl0, 0);
        check("t1_no_err", fe_cnt - fe0, 0);
        tick(10);

        // ---- 2: read 0x05 returns 0xA7
        do_read("t2_read", 7'h05);
        check("t2_wdata_hold", {24'd0, reg_wdata}, {24'd0, last_wdata});
        tick(10);

        // ---- 3: parity error, stop error, then a good read
        fe0 = fe_cnt;
        we0 = we_cnt;
        send_frame(8'h85, 1'b1, 1'b0);
        tick(3);
        check("t3_par_err", fe_cnt - fe0, 1);
        check("t3_par_no_we", we_cnt - we0, 0);
        check("t3_par_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1);
        tick(3);
        check("t3_stop_err", fe_cnt - fe0, 2);
        tick(BR);
        do_read("t3_read", 7'h05);
        check("t3_no_we", we_cnt - we0, 0);
        tick(10);

        // ---- 4: wdata timeout, next byte treated as a header
        fe0 = fe_cnt;
        re0 = re_cnt;
        send_frame(8'h85, 1'b0, 1'b0);
        w = 0;
        while (fe_cnt == fe0 && w < FRAME_TO + 3 * BR) begin
            @(negedge clk);
            w++;
        end
        tick(2);
        check("t4_timeout_err", fe_cnt - fe0, 1);
        check("t4_timeout_late", {31'd0, (w >= FRAME_TO - BR)}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_no_re", re_cnt - re0, 0);
        do_read("t4_hdr_read", 7'h3C);
        tick(10);

        // ---- 5: short glitch on rx
        fe0   = fe_cnt;
        we0   = we_cnt;
        re0   = re_cnt;
        busy0 = busy_cyc;
        rx = 1'b0;
        tick((3 * BR + 9) / 10);
        rx = 1'b1;
        tick(3 * BR);
        check("t5_no_err", fe_cnt - fe0, 0);
        check("t5_no_we", we_cnt - we0, 0);
        check("t5_no_re", re_cnt - re0, 0);
        check("t5_no_busy", busy_cyc - busy0, 0);

        // ---- 6: reset in the middle of a reply
        rf[7'h12] = 8'h6D;
        we0 = we_cnt;
        send_frame(8'h12, 1'b0, 1'b0);
        w = 0;
        while (tx !== 1'b0 && w < TURN_DLY + 4 * BR) begin
            @(negedge clk);
            w++;
        end
        check("t6_tx_started", {31'd0, tx}, 32'd0);
        tick(4 * BR + BR / 2);
        rst = 1'b1;
        tick(1);
        check("t6_rst_tx", {31'd0, tx}, 32'd1);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        tick(2);
        rst = 1'b0;
        txl0 = txlow_cyc;
        tick(3 * BR);
        check("t6_tx_quiet", txlow_cyc - txl0, 0);
        check("t6_no_we", we_cnt - we0, 0);
        check("t6_addr_clr", {25'd0, reg_addr}, 32'd0);
        do_write("t6_write", 7'h01, 8'hFF, 3);
        last_wdata = 8'hFF;
        tick(10);

        // ---- random mix of reads and writes
        fe0 = fe_cnt;
        for (int n = 0; n < 14; n++) begin
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write($sformatf("rnd%0d_wr", n), a, d, int'($urandom_range(0, 40)));
                last_wdata = d;
                rf[a] = d;
            end else begin
                do_read($sformatf("rnd%0d_rd", n), a);
                check($sformatf("rnd%0d_wdata_hold", n), {24'd0, reg_wdata}, {24'd0, last_wdata});
            end
            tick(int'($urandom_range(1, 20)));
        end
        check("rnd_no_err", fe_cnt - fe0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
